layer0_feature_packer: RTL and testbench

Input stage directly upstream of the layer-0 LUT neurons. It accepts a stream of signed readout samples over a valid/ready handshake and quantizes each sample to IN_BITS by arithmetic shift and saturation. It packs NUM_FEAT quantized features into one flat vector and holds that vector, with its own valid/ready handshake, for the layer-0 neuron array. Each layer-0 neuron takes its 6-bit input as a fixed slice of m_data.

---
 rtl/layer0_feature_packer.sv | 112 +++++++++++
 tb/tb_layer0_feature_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer0_feature_packer.sv
// Input stage for the layer-0 LUT neurons: quantizes signed samples by shift and saturation,
// packs NUM_FEAT features per frame, and holds the packed vector behind a valid/ready handshake.
//
// state | meaning
// FILL  | accepting samples into acc; a complete frame goes to the output register when it is free
// HOLD  | complete frame parked in acc; waiting for the downstream to consume the current vector
module layer0_feature_packer #(
    parameter int NUM_FEAT = 16,
    parameter int S_W      = 16,
    parameter int IN_BITS  = 2,
    parameter int SHIFT    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [S_W-1:0]               s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_FEAT*IN_BITS-1:0]  m_data,
    output logic                         err_pulse,
    output logic [7:0]                   drop_cnt
);

    localparam int VEC_W    = NUM_FEAT * IN_BITS;
    localparam int CNT_W    = $clog2(NUM_FEAT);
    localparam int LAST_LSB = (NUM_FEAT - 1) * IN_BITS;
    localparam logic [CNT_W-1:0]        LAST  = CNT_W'(NUM_FEAT - 1);
    localparam logic signed [S_W-1:0]   Q_MAX = S_W'(2 ** (IN_BITS - 1) - 1);
    localparam logic signed [S_W-1:0]   Q_MIN = S_W'(-(2 ** (IN_BITS - 1)));

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [VEC_W-1:0]        acc;
    logic [VEC_W-1:0]        full_vec;
    logic signed [S_W-1:0]   shifted;
    logic [IN_BITS-1:0]      q;
    logic                    accept;
    logic                    out_free;
    logic                    drop;

    always_comb begin
        shifted = $signed(s_data) >>> SHIFT;
        if (shifted > Q_MAX)
            q = Q_MAX[IN_BITS-1:0];
        else if (shifted < Q_MIN)
            q = Q_MIN[IN_BITS-1:0];
        else
            q = shifted[IN_BITS-1:0];
    end

    always_comb begin
        full_vec = acc;
        full_vec[LAST_LSB +: IN_BITS] = q;
    end

    assign s_ready  = rst_n && (state == FILL);
    assign accept   = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;
    // A frame is bad when s_last does not coincide with the final slot (short or long).
    assign drop     = accept && ((cnt == LAST) != s_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            acc       <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            err_pulse <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            err_pulse <= drop;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (m_valid && m_ready)
                m_valid <= 1'b0;

            case (state)
                FILL: begin
                    if (accept) begin
                        acc[cnt*IN_BITS +: IN_BITS] <= q;
                        if (drop) begin
                            cnt <= '0;
                        end else if (cnt != LAST) begin
                            cnt <= cnt + 1'b1;
                        end else if (out_free) begin
                            m_data  <= full_vec;
                            m_valid <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (m_valid && m_ready) begin
                        m_data  <= acc;
                        m_valid <= 1'b1;
                        cnt     <= '0;
                        state   <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_layer0_feature_packer.sv
// Scoreboard bench for layer0_feature_packer: a frame-level reference model fills an expected
// queue at each accepted sample, and a monitor pops and compares at every output handshake.
module tb_layer0_feature_packer;

    localparam int NF = 16;
    localparam int SW = 16;
    localparam int IB = 2;
    localparam int SH = 8;
    localparam int VW = NF * IB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [SW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [VW-1:0] m_data;
    logic          err_pulse;
    logic [7:0]    drop_cnt;

    layer0_feature_packer #(.NUM_FEAT(NF), .S_W(SW), .IN_BITS(IB), .SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_pulse(err_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    int            cycle = 0;
    logic [VW-1:0] exp_q[$];
    int            cur[$];
    int            model_drops = 0;
    int            err_seen = 0;
    bit            streaming = 0;
    int            stream_vecs = 0;
    int            last_cyc = 0;
    bit            rand_mr = 0;
    bit            prev_stall = 0;
    bit            prev_rst = 0;
    logic [VW-1:0] prev_data = '0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int quant(input logic [SW-1:0] d);
        int v;
        v = int'($signed(d));
        v = v >>> SH;  // floor division by 2^SH
        if (v > 2 ** (IB - 1) - 1) v = 2 ** (IB - 1) - 1;
        if (v < -(2 ** (IB - 1))) v = -(2 ** (IB - 1));
        return v;
    endfunction

    function automatic logic [VW-1:0] pack(input int f[$]);
        logic [VW-1:0] vec = '0;
        for (int k = 0; k < f.size(); k++)
            vec |= VW'(f[k] & (2 ** IB - 1)) << (k * IB);
        return vec;
    endfunction

    function automatic int exp_drop_cnt();
        return (model_drops > 255) ? 255 : model_drops;
    endfunction

    task automatic model_accept(input logic [SW-1:0] d, input logic l);
        cur.push_back(quant(d));
        if (l) begin
            if (cur.size() == NF) exp_q.push_back(pack(cur));
            else model_drops++;
            cur.delete();
        end else if (cur.size() == NF) begin
            model_drops++;
            cur.delete();
        end
    endtask

    task automatic send(input logic [SW-1:0] d, input logic l);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready stuck at 0 for %0d cycles", t);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(d, l);
        #1 s_valid = 1'b0;
    endtask

    function automatic logic [SW-1:0] rand_sample();
        if ($urandom_range(0, 1) == 0) return SW'($urandom());
        return SW'(int'($urandom_range(0, 1023)) - 512);
    endfunction

    task automatic send_frame(input int len);
        for (int i = 0; i < len; i++) begin
            send(rand_sample(), (i == len - 1));
            if (rand_mr && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        cur.delete();
        model_drops = 0;
        err_seen = 0;
        @(negedge clk);
        check("s_ready_in_reset", s_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (err_pulse) err_seen++;
            if (streaming && s_valid) check("stream_s_ready", s_ready, 1);
            if (prev_stall && prev_rst) check("hold_stable", m_data, prev_data);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_vector: got %0h expected none", m_data);
                end else begin
                    check("vector", m_data, exp_q.pop_front());
                end
                if (streaming) begin
                    if (stream_vecs > 0) check("stream_spacing", cycle - last_cyc, NF);
                    last_cyc = cycle;
                    stream_vecs++;
                end
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_rst   = rst_n;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mr) m_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        logic [SW-1:0] qvec[16];
        logic [VW-1:0] vec_a;
        logic [VW-1:0] vec_b;

        // Reset state
        idle(2);
        do_reset();

        // Quantization frame
        qvec = '{16'h0150, 16'h7FFF, 16'hFF00, 16'h8000, 16'h00FF, 16'hFFFF,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < NF; i++) send(qvec[i], (i == NF - 1));
        check("quant_m_valid", m_valid, 1);
        // features 01,01,11,10,00,11 then zeros
        check("quant_m_data", m_data, 32'h0000_0CB5);
        idle(1);

        // Short frame
        for (int i = 0; i < 5; i++) send(rand_sample(), (i == 4));
        check("short_err_pulse", err_pulse, 1);
        check("short_drop_cnt", drop_cnt, 1);
        check("short_m_valid", m_valid, 0);
        idle(1);
        check("short_err_one_cycle", err_pulse, 0);
        send_frame(NF);
        check("after_short_m_valid", m_valid, 1);
        idle(1);

        // Long frame: 16th sample without s_last, 17th starts a new frame
        for (int i = 0; i < NF; i++) send(rand_sample(), 1'b0);
        check("long_err_pulse", err_pulse, 1);
        check("long_drop_cnt", drop_cnt, 2);
        send_frame(NF);
        check("after_long_m_valid", m_valid, 1);
        check("long_err_total", err_seen, model_drops);
        idle(1);

        // Backpressure: A held, B parked, then both released in order
        m_ready = 1'b0;
        send_frame(NF);
        send_frame(NF);
        check("bp_s_ready_hold", s_ready, 0);
        check("bp_queue_depth", exp_q.size(), 2);
        vec_a = exp_q[0];
        vec_b = exp_q[1];
        check("bp_a_on_output", m_data, vec_a);
        idle(3);
        check("bp_a_still_held", m_data, vec_a);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_b_loaded", m_data, vec_b);
        check("bp_b_valid", m_valid, 1);
        check("bp_s_ready_back", s_ready, 1);
        drain();

        // Streaming: 8 back-to-back frames
        stream_vecs = 0;
        streaming = 1;
        for (int f = 0; f < 8; f++) send_frame(NF);
        drain();
        streaming = 0;
        check("stream_vec_count", stream_vecs, 8);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) send(rand_sample(), 1'b0);
        do_reset();

        // Reset while in HOLD
        m_ready = 1'b0;
        send_frame(NF);
        send_frame(NF);
        check("hold_before_reset", s_ready, 0);
        do_reset();
        m_ready = 1'b1;

        // Random frames with random backpressure
        rand_mr = 1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) < 7) send_frame(NF);
            else send_frame(int'($urandom_range(1, 20)));
        end
        if (cur.size() > 0) send_frame(NF - cur.size());
        rand_mr = 0;
        #1 m_ready = 1'b1;
        drain();
        idle(2);
        check("rand_drop_cnt", drop_cnt, exp_drop_cnt());
        check("rand_err_count", err_seen, model_drops);

        // drop_cnt saturation
        do_reset();
        for (int i = 0; i < 300; i++) send(rand_sample(), 1'b1);
        idle(2);
        check("sat_drop_cnt", drop_cnt, exp_drop_cnt());
        check("sat_drop_cnt_255", drop_cnt, 255);
        check("sat_err_count", err_seen, 300);
        check("sat_no_output", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
